// File: rtl/addsub_16bit_serial.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// addsub_16bit_serial
//
// Saturating two's-complement adder/subtractor. It processes one SLICE-bit
// carry-lookahead slice per clock cycle, least significant slice first, and
// keeps a registered carry between slices. This trades latency for a narrow
// datapath.
//
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operand packet valid
//   in_ready   block can accept an operand packet (IDLE only)
//   A, B       operands, two's complement, WIDTH bits
//   Sub        0 = A+B, 1 = A-B
//   out_valid  Sum/Ovfl hold a completed result (DONE only)
//   out_ready  consumer accepts the result
//   Sum        saturated result, WIDTH bits
//   Ovfl       signed overflow occurred for this operation
//
// Timing: an operand accepted at edge N produces out_valid after edge
// N+WIDTH/SLICE. The result is held until out_ready is asserted. in_ready
// returns in the cycle after the handoff.
// ---------------------------------------------------------------------------
module addsub_16bit_serial #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Ovfl
);

  localparam int NSL = WIDTH / SLICE;
  localparam int CW  = (NSL > 1) ? $clog2(NSL) : 1;
  localparam logic [CW-1:0]    LAST    = CW'(NSL - 1);
  localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] raw_q, raw_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             ovfl_q, ovfl_d;
  logic             in_ready_q, in_ready_d;

  // Operands shift right one slice per CALC cycle, so the active slice is
  // always the low SLICE bits. The raw result fills from the top.
  logic [SLICE-1:0] sl_a, sl_b, sl_g, sl_p, sl_s;
  logic [SLICE:0]   sl_c;
  logic             cla_acc, cla_term;
  logic [WIDTH-1:0] raw_shift;
  logic             ovf;

  assign sl_a = opa_q[SLICE-1:0];
  assign sl_b = opb_q[SLICE-1:0];

  for (genvar gi = 0; gi < SLICE; gi++) begin : g_slice
    assign sl_g[gi] = sl_a[gi] & sl_b[gi];
    assign sl_p[gi] = sl_a[gi] ^ sl_b[gi];
    assign sl_s[gi] = sl_p[gi] ^ sl_c[gi];
  end

  // Each carry in the slice is a flat sum-of-products of generate and
  // propagate terms. It does not ripple from the previous bit's carry:
  // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]c[0]
  always_comb begin
    sl_c     = '0;
    cla_acc  = 1'b0;
    cla_term = 1'b0;
    sl_c[0]  = carry_q;
    for (int i = 0; i < SLICE; i++) begin
      cla_acc = carry_q;
      for (int j = 0; j <= i; j++) cla_acc = cla_acc & sl_p[j];
      for (int j = 0; j <= i; j++) begin
        cla_term = sl_g[j];
        for (int k = j + 1; k <= i; k++) cla_term = cla_term & sl_p[k];
        cla_acc = cla_acc | cla_term;
      end
      sl_c[i+1] = cla_acc;
    end
  end

  assign raw_shift = WIDTH'({sl_s, raw_q} >> SLICE);

  // On the final slice, the low bits of the shifted operands hold the MSB
  // slice. opb_q is already inverted for subtraction, so the usual same-sign
  // rule also judges A-0x8000 correctly.
  assign ovf = (opa_q[SLICE-1] == opb_q[SLICE-1]) &&
               (sl_s[SLICE-1] != opa_q[SLICE-1]);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    raw_d   = raw_q;
    sum_d   = sum_q;
    ovfl_d  = ovfl_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          opa_d   = A;
          opb_d   = Sub ? ~B : B;
          carry_d = Sub;
          cnt_d   = '0;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        opa_d   = opa_q >> SLICE;
        opb_d   = opb_q >> SLICE;
        raw_d   = raw_shift;
        carry_d = sl_c[SLICE];
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = S_DONE;
          ovfl_d  = ovf;
          sum_d   = ovf ? (opa_q[SLICE-1] ? SAT_NEG : SAT_POS) : raw_shift;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // in_ready is registered. It stays low during reset and rises on the
  // first clock edge afterwards.
  assign in_ready_d = (state_d == S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      carry_q    <= 1'b0;
      opa_q      <= '0;
      opb_q      <= '0;
      raw_q      <= '0;
      sum_q      <= '0;
      ovfl_q     <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      carry_q    <= carry_d;
      opa_q      <= opa_d;
      opb_q      <= opb_d;
      raw_q      <= raw_d;
      sum_q      <= sum_d;
      ovfl_q     <= ovfl_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q == S_DONE);
  assign Sum       = sum_q;
  assign Ovfl      = ovfl_q;

endmodule

// File: tb/tb_addsub_16bit_serial.sv
`timescale 1ns/1ps
// Bench for addsub_16bit_serial. A cycle-level reference model checks the
// handshake and result outputs on every falling edge. Directed operations
// pin the model to hand-computed values. A randomized soak follows.
module tb_addsub_16bit_serial;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] A, B;
  logic        Sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] Sum;
  logic        Ovfl;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int edges_since_rst = 0;
  int txn      = 0;

  addsub_16bit_serial #(.WIDTH(16), .SLICE(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .Sub(Sub), .out_valid(out_valid), .out_ready(out_ready),
    .Sum(Sum), .Ovfl(Ovfl)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) edges_since_rst <= 0;
    else if (edges_since_rst < 1000) edges_since_rst <= edges_since_rst + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: exact signed arithmetic, clamped to the 16-bit range.
  function automatic logic [16:0] ref_calc(input logic [15:0] a, input logic [15:0] b, input logic sub);
    int r;
    r = sub ? (int'($signed(a)) - int'($signed(b))) : (int'($signed(a)) + int'($signed(b)));
    if (r > 32767)       return {1'b1, 16'h7FFF};
    else if (r < -32768) return {1'b1, 16'h8000};
    else                 return {1'b0, r[15:0]};
  endfunction

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic [16:0] res;
  } op_t;

  op_t exp_q[$];
  logic pending = 1'b0;
  int   acc_cyc = 0;

  // Reference model and compare process. It samples at the falling edge,
  // so an accept or handoff seen here takes effect at the next rising edge.
  initial begin
    logic exp_ov, exp_ir;
    op_t  o;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", 32'(Sum), 32'd0);
        chk("rst_ovfl", 32'(Ovfl), 32'd0);
        pending = 1'b0;
        exp_q.delete();
      end else begin
        exp_ov = pending && (cyc - acc_cyc >= 4);
        exp_ir = !pending && (edges_since_rst >= 1);
        chk("out_valid", 32'(out_valid), 32'(exp_ov));
        chk("in_ready", 32'(in_ready), 32'(exp_ir));
        if (exp_ov && out_valid && exp_q.size() > 0) begin
          chk("sum", 32'(Sum), 32'(exp_q[0].res[15:0]));
          chk("ovfl", 32'(Ovfl), 32'(exp_q[0].res[16]));
        end
        if (exp_ir && in_valid && in_ready) begin
          o.a = A; o.b = B; o.sub = Sub; o.res = ref_calc(A, B, Sub);
          exp_q.push_back(o);
          pending = 1'b1;
          acc_cyc = cyc + 1;
        end
        if (exp_ov && out_valid && out_ready) begin
          if (exp_q.size() > 0) begin
            txn++;
            $display("txn %0d: A=%h B=%h Sub=%0d -> Sum=%h Ovfl=%0d (model %h/%0d)",
                     txn, exp_q[0].a, exp_q[0].b, exp_q[0].sub, Sum, Ovfl,
                     exp_q[0].res[15:0], exp_q[0].res[16]);
            void'(exp_q.pop_front());
          end
          pending = 1'b0;
        end
      end
    end
  end

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) chk("in_ready_timeout", 32'd0, 32'd1);
  endtask

  // Run one directed operation. Inputs are scrambled during CALC. With hold
  // set, out_ready is held low for 10 cycles while a competing in_valid is
  // driven.
  task automatic run_op(input string name, input logic [15:0] a, input logic [15:0] b,
                        input logic sub, input logic [15:0] exp_sum, input logic exp_ovf,
                        input bit hold);
    bit ok;
    bit seen;
    int c0;
    chk({"model_", name}, 32'(ref_calc(a, b, sub)), 32'({exp_ovf, exp_sum}));
    wait_ready(ok);
    if (!ok) return;
    @(posedge clk); #1;
    A = a; B = b; Sub = sub; in_valid = 1'b1; out_ready = !hold;
    @(posedge clk); #1;
    c0 = cyc;
    in_valid = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 20; n++) begin
      A = 16'($urandom); B = 16'($urandom); Sub = 1'($urandom);
      @(negedge clk);
      if (out_valid) begin seen = 1'b1; break; end
      @(posedge clk); #1;
    end
    if (!seen) begin
      chk({name, "_out_valid_timeout"}, 32'd0, 32'd1);
      out_ready = 1'b1;
      return;
    end
    chk({name, "_latency"}, 32'(cyc - c0), 32'd4);
    chk({name, "_sum"}, 32'(Sum), 32'(exp_sum));
    chk({name, "_ovfl"}, 32'(Ovfl), 32'(exp_ovf));
    if (hold) begin
      for (int n = 0; n < 10; n++) begin
        @(posedge clk); #1;
        in_valid = 1'b1; A = 16'($urandom); B = 16'($urandom);
        @(negedge clk);
        chk({name, "_hold_valid"}, 32'(out_valid), 32'd1);
        chk({name, "_hold_sum"}, 32'(Sum), 32'(exp_sum));
        chk({name, "_hold_in_ready"}, 32'(in_ready), 32'd0);
      end
      @(posedge clk); #1;
      in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
    end
    @(posedge clk); #1;
    @(negedge clk);
    chk({name, "_ready_after_handoff"}, 32'(in_ready), 32'd1);
    chk({name, "_valid_after_handoff"}, 32'(out_valid), 32'd0);
  endtask

  // Assert reset asynchronously in the 2nd CALC cycle. The outputs must
  // clear without waiting for a clock edge.
  task automatic reset_mid_op();
    bit ok;
    wait_ready(ok);
    if (!ok) return;
    @(posedge clk); #1;
    A = 16'h1234; B = 16'h1111; Sub = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", 32'(out_valid), 32'd0);
    chk("async_rst_sum", 32'(Sum), 32'd0);
    chk("async_rst_ovfl", 32'(Ovfl), 32'd0);
    chk("async_rst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  function automatic logic [15:0] pick_operand();
    logic [15:0] corners [4];
    corners[0] = 16'h0000; corners[1] = 16'h7FFF;
    corners[2] = 16'h8000; corners[3] = 16'hFFFF;
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 3)];
    return 16'($urandom);
  endfunction

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; A = '0; B = '0; Sub = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    run_op("sub_5_3",      16'h0005, 16'h0003, 1'b1, 16'h0002, 1'b0, 1'b0);
    run_op("carry_chain",  16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0);
    run_op("ffff_m_8000",  16'hFFFF, 16'h8000, 1'b1, 16'h7FFF, 1'b0, 1'b0);
    run_op("pos_sat",      16'h7FFF, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b0);
    run_op("neg_sat",      16'h8000, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b0);
    reset_mid_op();
    run_op("zero_m_8000",  16'h0000, 16'h8000, 1'b1, 16'h7FFF, 1'b1, 1'b0);
    run_op("backpressure", 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b1);

    // Randomized soak. The compare process checks every cycle.
    for (int n = 0; n < 4000; n++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      A         = pick_operand();
      B         = pick_operand();
      Sub       = 1'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (12) @(posedge clk);
    @(negedge clk);
    chk("drain_idle", 32'(in_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
